dct_block_loader: RTL and testbench
===================================

# dct_block_loader

Front-end stage for the 4-point DCT. It accepts a serial stream of 8-bit samples over a valid/ready handshake and packs them into 4-sample blocks. Each block is presented on a parallel output that drives the DCT's `dt_i[0:3]` input directly. Two block buffers (ping-pong) let one block be held stable at the DCT input while the next block fills.

## Interface
Parameters:
- `NPTS`, 4: samples per block; fixed to the DCT width, and only 4 is supported.
- `DW`, 8: sample width in bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `smp_i`, input, DW: incoming sample; signed, or an unsigned pixel under `LEVEL_SHIFT_EN`.
- `smp_valid_i`, input, 1: `smp_i` is valid.
- `smp_ready_o`, output, 1: loader can accept a sample this cycle.
- `flush_i`, input, 1: close the partial block, padding the remaining elements with zeros.
- `blk_o[0:NPTS-1]`, output, DW each, signed: block elements, connected to the DCT `dt_i`.
- `blk_valid_o`, output, 1: `blk_o` holds a complete block.
- `blk_ready_i`, input, 1: consumer takes the block this cycle.

## Operation
- State:
  - Two buffers `buf[0..1][0..3]`.
  - Per-buffer `full` flags.
  - Write pointer `wsel`, read pointer `rsel`.
  - Fill counter `cnt` (0..3).
- **Accept rule.** A sample is accepted when `smp_valid_i && smp_ready_o`.
  - The accepted sample is written to `buf[wsel][cnt]`, and `cnt` increments.
  - The first sample of a block lands in element 0.
- **Input ready.** `smp_ready_o = !full[wsel]`. It depends only on registered state, never combinationally on `blk_ready_i`.
- **Block complete.** When the sample accepted at `cnt==3` arrives:
  - `full[wsel]` is set.
  - `wsel` toggles.
  - `cnt` returns to 0.
- **Flush.** On `flush_i`, with `k` = the value of `cnt` after any same-cycle accept:
  - If `k>0`, elements `k..3` are written as 0, `full[wsel]` is set, `wsel` toggles and `cnt` goes to 0.
  - If `k==0`, flush is ignored, including the case where the same-cycle sample completed the block normally.
  - A flush while `full[wsel]` is set is ignored.
- **Output.**
  - `blk_valid_o = full[rsel]`.
  - `blk_o = buf[rsel]` when valid; otherwise `blk_o` is all zeros.
  - On `blk_valid_o && blk_ready_i`, `full[rsel]` clears and `rsel` toggles.
- **Stability.** `blk_o` is stable while `blk_valid_o` is high and `blk_ready_i` is low.
- **Simultaneous fill and drain.** A fill and a drain in the same cycle always target different buffers and both take effect.
- **Both buffers full.** `smp_ready_o` is 0. A drain in cycle N raises `smp_ready_o` in cycle N+1.
- **Sample state.** There is no state machine beyond this. `(cnt, full[wsel])` forms the fill state: `EMPTY`, `FILLING` (cnt 1..3), `BLOCKED` (`full[wsel]`).

## Timing
- **Reset values.** While `rst_n` is low, and on release:
  - `blk_valid_o=0`, `blk_o` all 0, `smp_ready_o=1`.
  - `cnt=0`, `wsel=rsel=0`, both `full=0`, buffers 0.
  - Upstream must not assert `smp_valid_i` during reset.
- **Reset mid-operation.** Asserting `rst_n` low drops `blk_valid_o` immediately, asynchronously. Partial and full blocks are discarded.
- **Latency.** When the 4th sample is accepted at edge N, `blk_valid_o` rises after edge N and stays high until accepted.
- **Throughput.**
  - With `blk_ready_i` held high: one block per 4 cycles, and `smp_ready_o` never drops.
  - Sustained stream with the consumer stalled: at most 8 samples are buffered.
- **DCT path.** The downstream DCT is combinational. Its coefficients are valid in the same cycle as `blk_valid_o`.

## Configuration
- `LEVEL_SHIFT_EN`
  - **Defined:** `smp_i` is an unsigned pixel (0..255). The stored value is `smp_i − 128`, implemented as an MSB inversion. Flush padding is still 0 after the shift.
  - **Undefined:** `smp_i` is stored unchanged as two's-complement signed.

## Test plan
- **Reset.** Hold `rst_n` low for 3 cycles and release → `blk_valid_o=0`, `blk_o={0,0,0,0}`, `smp_ready_o=1`.
- **Basic block.** Stream 5,10,20,0 back-to-back with `blk_ready_i=1` → `blk_valid_o` high for exactly one cycle, starting the cycle after the 4th accept, with `blk_o={5,10,20,0}`. With `LEVEL_SHIFT_EN`, inputs 133,138,148,128 must give the same block.
- **Backpressure.** Hold `blk_ready_i=0` and stream 0x27,0x53,0x50,0x06,1,2,3,4 → after the 8th accept, `smp_ready_o=0` and the 9th sample is held off. `blk_o={0x27,0x53,0x50,0x06}` stays stable. Pulse `blk_ready_i` for one cycle → next cycle `blk_o={1,2,3,4}` and `smp_ready_o=1`.
- **Flush.**
  - Accept −3,7, then `flush_i` → block `{−3,7,0,0}`.
  - `flush_i` with `cnt==0` → no block.
  - `flush_i` in the cycle of the 2nd accept (9 then 4) → `{9,4,0,0}`.
- **Simultaneous fill/drain.** Buffer 0 full, `blk_ready_i=1` in the same cycle the 4th sample of buffer 1 is accepted → `blk_valid_o` stays high and `blk_o` switches to buffer 1's block on the next cycle.
- **Reset mid-operation.** One full block plus 2 samples pending, then drive `rst_n` low between edges → `blk_valid_o` falls before the next edge. After release, stream 1,2,3,4 → `blk_o={1,2,3,4}`.

Source files
------------

// File: rtl/dct_block_loader_if.sv
// ============================================================================
// Module      : dct_block_loader_if
// Description : Sample-stream and block-output handshake bundle for the
//               DCT block loader. The master side produces samples and
//               consumes blocks; the slave side is the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dct_block_loader_if #(
  parameter int NPTS = 4,
  parameter int DW   = 8
);
  logic        [DW-1:0] smp_i;
  logic                 smp_valid_i;
  logic                 smp_ready_o;
  logic                 flush_i;
  logic signed [DW-1:0] blk_o [0:NPTS-1];
  logic                 blk_valid_o;
  logic                 blk_ready_i;

  modport master (
    output smp_i, smp_valid_i, flush_i, blk_ready_i,
    input  smp_ready_o, blk_o, blk_valid_o
  );

  modport slave (
    input  smp_i, smp_valid_i, flush_i, blk_ready_i,
    output smp_ready_o, blk_o, blk_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/dct_block_loader.sv
// ============================================================================
// Module      : dct_block_loader
// Description : Packs a serial valid/ready sample stream into 4-sample blocks
//               using two ping-pong buffers. One block is held stable at the
//               DCT input while the other fills. A flush closes a partial
//               block with zero padding.
//               Optional macro LEVEL_SHIFT_EN: samples are unsigned pixels and
//               are stored as (sample - 128) via MSB inversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_block_loader #(
  parameter int NPTS = 4,
  parameter int DW   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dct_block_loader_if.slave  bus
);

  localparam int             c_CW   = $clog2(NPTS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(NPTS - 1);

  logic signed [DW-1:0] r_buf [0:1][0:NPTS-1];
  logic [1:0]           r_full;
  logic                 r_wsel;
  logic                 r_rsel;
  logic [c_CW-1:0]      r_cnt;

  logic                 w_acc;
  logic                 w_complete;
  logic                 w_flush;
  logic                 w_close;
  logic                 w_drain;
  logic [c_CW:0]        w_k;
  logic [1:0]           w_full_nxt;
  logic signed [DW-1:0] w_smp_st;

`ifdef LEVEL_SHIFT_EN
  // Unsigned pixel minus 128 is just the MSB flipped.
  assign w_smp_st = {~bus.smp_i[DW-1], bus.smp_i[DW-2:0]};
`else
  assign w_smp_st = bus.smp_i;
`endif

  assign bus.smp_ready_o = ~r_full[r_wsel];
  assign bus.blk_valid_o = r_full[r_rsel];

  assign w_acc      = bus.smp_valid_i & ~r_full[r_wsel];
  assign w_complete = w_acc & (r_cnt == c_LAST);
  // Fill level after any same-cycle accept; a completed block reads as NPTS.
  assign w_k        = {1'b0, r_cnt} + {{c_CW{1'b0}}, w_acc};
  // A flush only acts on a non-empty partial block in a free buffer.
  assign w_flush    = bus.flush_i & ~r_full[r_wsel] & (w_k != '0) & ~w_complete;
  assign w_close    = w_complete | w_flush;
  assign w_drain    = r_full[r_rsel] & bus.blk_ready_i;

  // Full flags: drain and close always address different buffers.
  always_comb begin
    w_full_nxt = r_full;
    if (w_drain) w_full_nxt[r_rsel] = 1'b0;
    if (w_close) w_full_nxt[r_wsel] = 1'b1;
  end

  // Buffer storage, pointers, fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < NPTS; e++) begin
          r_buf[b][e] <= '0;
        end
      end
      r_full <= '0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) begin
        r_buf[r_wsel][r_cnt] <= w_smp_st;
      end
      // Padding positions are all beyond the accepted element, so no overlap.
      if (w_flush) begin
        for (int e = 0; e < NPTS; e++) begin
          if (e >= int'(w_k)) begin
            r_buf[r_wsel][e] <= '0;
          end
        end
      end
      if (w_close) r_wsel <= ~r_wsel;
      if (w_drain) r_rsel <= ~r_rsel;
      r_full <= w_full_nxt;
      if (w_close) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Present the read buffer only while it holds a complete block.
  for (genvar g = 0; g < NPTS; g++) begin : g_blk
    assign bus.blk_o[g] = r_full[r_rsel] ? r_buf[r_rsel][g] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_dct_block_loader.sv
// ============================================================================
// Module      : tb_dct_block_loader
// Description : Directed table-driven bench for dct_block_loader, plus
//               hand-written reset sequences. Works with or without
//               LEVEL_SHIFT_EN (samples are re-encoded as pixels when set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_block_loader;

  typedef struct {
    logic [7:0]  smp;
    logic        v;
    logic        fl;
    logic        rdy;
    logic        e_sr;
    logic        e_bv;
    logic [31:0] e_blk;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[$];

  dct_block_loader_if #(.NPTS(4), .DW(8)) bus ();

  dct_block_loader #(.NPTS(4), .DW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed sample value to the encoding the DUT expects on smp_i.
  function automatic logic [7:0] enc(input logic [7:0] s);
`ifdef LEVEL_SHIFT_EN
    return s ^ 8'h80;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [31:0] got_blk();
    return {bus.blk_o[0], bus.blk_o[1], bus.blk_o[2], bus.blk_o[3]};
  endfunction

  task automatic add(input logic [7:0] smp, input logic v, input logic fl,
                     input logic rdy, input logic esr, input logic ebv,
                     input logic [31:0] eblk);
    vec_t r;
    r.smp = smp; r.v = v; r.fl = fl; r.rdy = rdy;
    r.e_sr = esr; r.e_bv = ebv; r.e_blk = eblk;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int row, input logic esr,
                         input logic ebv, input logic [31:0] eblk);
    chk({tag, "_smp_ready"}, row, {31'd0, bus.smp_ready_o}, {31'd0, esr});
    chk({tag, "_blk_valid"}, row, {31'd0, bus.blk_valid_o}, {31'd0, ebv});
    chk({tag, "_blk"}, row, got_blk(), eblk);
  endtask

  task automatic drive(input logic [7:0] smp, input logic v, input logic fl,
                       input logic rdy);
    bus.smp_i       = enc(smp);
    bus.smp_valid_i = v;
    bus.flush_i     = fl;
    bus.blk_ready_i = rdy;
  endtask

  task automatic step(input logic [7:0] smp, input logic v, input logic fl,
                      input logic rdy);
    drive(smp, v, fl, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(8'd0, 1'b0, 1'b0, 1'b0);

    // smp, v, fl, rdy | smp_ready, blk_valid, blk
    // Basic block with consumer ready
    add(8'd5,  1, 0, 1, 1, 0, 32'h0);
    add(8'd10, 1, 0, 1, 1, 0, 32'h0);
    add(8'd20, 1, 0, 1, 1, 0, 32'h0);
    add(8'd0,  1, 0, 1, 1, 1, pk(8'd5, 8'd10, 8'd20, 8'd0));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    // Backpressure: fill both buffers
    add(8'h27, 1, 0, 0, 1, 0, 32'h0);
    add(8'h53, 1, 0, 0, 1, 0, 32'h0);
    add(8'h50, 1, 0, 0, 1, 0, 32'h0);
    add(8'h06, 1, 0, 0, 1, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'd1,  1, 0, 0, 1, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'd2,  1, 0, 0, 1, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'd3,  1, 0, 0, 1, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'd4,  1, 0, 0, 0, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'h77, 1, 0, 0, 0, 1, pk(8'h27, 8'h53, 8'h50, 8'h06));
    add(8'h77, 1, 0, 1, 1, 1, pk(8'd1, 8'd2, 8'd3, 8'd4));
    add(8'd0,  0, 0, 0, 1, 1, pk(8'd1, 8'd2, 8'd3, 8'd4));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    // Flush of a 2-sample partial block
    add(8'hFD, 1, 0, 0, 1, 0, 32'h0);
    add(8'd7,  1, 0, 0, 1, 0, 32'h0);
    add(8'd0,  0, 1, 0, 1, 1, pk(8'hFD, 8'd7, 8'd0, 8'd0));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    // Flush with nothing pending
    add(8'd0,  0, 1, 0, 1, 0, 32'h0);
    add(8'd0,  0, 0, 0, 1, 0, 32'h0);
    // Flush in the cycle of the 2nd accept (buffer previously held 1,2,3,4)
    add(8'd9,  1, 0, 0, 1, 0, 32'h0);
    add(8'd4,  1, 1, 0, 1, 1, pk(8'd9, 8'd4, 8'd0, 8'd0));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    // Flush coinciding with a normal completion: no extra block
    add(8'd11, 1, 0, 0, 1, 0, 32'h0);
    add(8'd12, 1, 0, 0, 1, 0, 32'h0);
    add(8'd13, 1, 0, 0, 1, 0, 32'h0);
    add(8'd14, 1, 1, 0, 1, 1, pk(8'd11, 8'd12, 8'd13, 8'd14));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);
    add(8'd0,  0, 0, 0, 1, 0, 32'h0);
    // Simultaneous fill of buffer 1 and drain of buffer 0
    add(8'd21, 1, 0, 0, 1, 0, 32'h0);
    add(8'd22, 1, 0, 0, 1, 0, 32'h0);
    add(8'd23, 1, 0, 0, 1, 0, 32'h0);
    add(8'd24, 1, 0, 0, 1, 1, pk(8'd21, 8'd22, 8'd23, 8'd24));
    add(8'd31, 1, 0, 0, 1, 1, pk(8'd21, 8'd22, 8'd23, 8'd24));
    add(8'd32, 1, 0, 0, 1, 1, pk(8'd21, 8'd22, 8'd23, 8'd24));
    add(8'd33, 1, 0, 0, 1, 1, pk(8'd21, 8'd22, 8'd23, 8'd24));
    add(8'd34, 1, 0, 1, 1, 1, pk(8'd31, 8'd32, 8'd33, 8'd34));
    add(8'd0,  0, 0, 1, 1, 0, 32'h0);

    // Reset held for 3 cycles, checked during and after release
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", -1, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk_all("rst_rel", -1, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].smp, vecs[i].v, vecs[i].fl, vecs[i].rdy);
      chk_all("vec", i, vecs[i].e_sr, vecs[i].e_bv, vecs[i].e_blk);
    end

    // Reset mid-operation: one full block plus two pending samples
    step(8'd41, 1, 0, 0);
    step(8'd42, 1, 0, 0);
    step(8'd43, 1, 0, 0);
    step(8'd44, 1, 0, 0);
    step(8'd45, 1, 0, 0);
    step(8'd46, 1, 0, 0);
    drive(8'd0, 0, 0, 0);
    chk_all("pre_rst", -2, 1'b1, 1'b1, pk(8'd41, 8'd42, 8'd43, 8'd44));
    #2;
    rst_n = 1'b0;
    #2;
    chk_all("mid_rst", -2, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(8'd1, 1, 0, 0);
    step(8'd2, 1, 0, 0);
    step(8'd3, 1, 0, 0);
    chk_all("post_rst_fill", -3, 1'b1, 1'b0, 32'h0);
    step(8'd4, 1, 0, 0);
    chk_all("post_rst_blk", -3, 1'b1, 1'b1, pk(8'd1, 8'd2, 8'd3, 8'd4));
    step(8'd0, 0, 0, 1);
    chk_all("post_rst_drain", -3, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
